adder_seq: RTL

- Parametrised, multi-cycle ripple-chunk adder/subtractor for the ALU datapath.
- Computes one CHUNK-bit slice per clock, carrying between slices in a register. This trades latency for a short carry chain.
- Adds a subtract mode, carry-out and signed-overflow flags, and valid/ready handshakes on both sides, so it can replace a fixed combinational adder where timing is critical.

---
 rtl/adder_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/adder_seq.sv
// Multi-cycle ripple-chunk adder/subtractor: one CHUNK-bit slice per clock,
// with the carry held in a register between slices.
module adder_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] opa, opb;
    logic [CHUNK:0]   sum;
    logic             last;

    assign last = (idx == LAST);
    assign busy = (state != IDLE);

    // opb already holds ~b for subtraction; carry-in supplies the +1.
    always_comb begin
        sum = {1'b0, opa[idx*CHUNK +: CHUNK]} + {1'b0, opb[idx*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, carry};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx      <= '0;
            carry    <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    result[idx*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
                    carry <= sum[CHUNK];
                    // Counter saturates at the last slice.
                    idx   <= last ? idx : idx + 1'b1;
                    if (last) begin
                        cout     <= sum[CHUNK];
                        overflow <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                                    (sum[CHUNK-1] != opa[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
